conv_1x1_layer_ctrl: RTL and testbench
======================================

CONV_1X1_LAYER_CTRL -- requirements
Module: conv_1x1_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: pixel/weight word width.
REQ-002 SHALL have parameter CHANNEL_NUM_IN, default 128: input channels per output channel.
REQ-003 SHALL have parameter CHANNEL_NUM_OUT, default 512: output channels sequenced per layer.
REQ-004 SHALL have parameter IMAGE_SIZE, default 306*306: pixels per channel.
REQ-005 SHALL have parameter W_ADDR_WIDTH, default 16: weight memory address width, which SHALL hold CHANNEL_NUM_IN*CHANNEL_NUM_OUT-1.
REQ-006 SHALL have parameter F_ADDR_WIDTH, default 24: feature memory address width, which SHALL hold CHANNEL_NUM_IN*IMAGE_SIZE-1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low reset; sampled only on the clk rising edge, reset==0 resets.
REQ-009 SHALL have port start, input, 1 bit: one-cycle layer start request.
REQ-010 SHALL have ports w_rd_en (output, 1), w_rd_addr (output, W_ADDR_WIDTH) and w_rd_data (input, DATA_WIDTH): the weight memory read port; data SHALL return exactly one cycle after w_rd_en.
REQ-011 SHALL have ports f_rd_en (output, 1), f_rd_addr (output, F_ADDR_WIDTH) and f_rd_data (input, DATA_WIDTH): the feature memory read port, also with 1-cycle latency.
REQ-012 SHALL have ports weight_out (output, DATA_WIDTH) and valid_weight_out (output, 1): to the conv weight_in/valid_weight_in.
REQ-013 SHALL have ports pxl_out (output, DATA_WIDTH) and valid_out (output, 1): to the conv pixel path pxl_in/valid_in.
REQ-014 SHALL have port result_valid_in, input, 1 bit: valid_out of the downstream channel adder.
REQ-015 SHALL have ports busy (output, 1), done (output, 1), oc_idx (output, clog2(CHANNEL_NUM_OUT) bits) and err (output, 1).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_W, STREAM, WAIT_RES, NEXT and FIN.
REQ-017 IDLE: start==1 SHALL move the FSM to LOAD_W with oc_idx=0; start SHALL be ignored in every state except IDLE.
REQ-018 LOAD_W: SHALL assert w_rd_en for CHANNEL_NUM_IN consecutive cycles with w_rd_addr = oc_idx*CHANNEL_NUM_IN + i, i=0..CHANNEL_NUM_IN-1, then enter STREAM.
REQ-019 Weights: each w_rd_data SHALL be registered onto weight_out with valid_weight_out=1, two cycles after its w_rd_en; valid_weight_out SHALL stay gap-free for CHANNEL_NUM_IN cycles.
REQ-020 STREAM: SHALL assert f_rd_en for CHANNEL_NUM_IN*IMAGE_SIZE consecutive cycles with f_rd_addr incrementing from 0 by 1, then enter WAIT_RES.
REQ-021 The first f_rd_en SHALL occur no earlier than the cycle after the last w_rd_en.
REQ-022 Pixels: pxl_out/valid_out SHALL follow f_rd_data/f_rd_en with the same 2-cycle alignment as weights.
REQ-023 valid_out and valid_weight_out SHALL never both be 1 in the same cycle.
REQ-024 Result counter: SHALL count result_valid_in cycles in STREAM and WAIT_RES, from 0 up to IMAGE_SIZE.
REQ-025 WAIT_RES: when the count reaches IMAGE_SIZE, SHALL clear the counter and enter NEXT.
REQ-026 NEXT (1 cycle): if oc_idx==CHANNEL_NUM_OUT-1 SHALL enter FIN; otherwise SHALL increment oc_idx and enter LOAD_W.
REQ-027 FIN (1 cycle): SHALL pulse done=1 for exactly one cycle and return to IDLE; oc_idx SHALL hold its last value until the next start.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 err SHALL be set sticky on either condition: result_valid_in==1 in IDLE, LOAD_W, NEXT or FIN; or result_valid_in==1 while the count already equals IMAGE_SIZE.
REQ-030 err SHALL be cleared only by reset or by an accepted start; the erroneous pulse itself SHALL NOT be counted.
REQ-031 All address arithmetic SHALL be unsigned with no wrap within a layer; the weight address after the last output channel SHALL be CHANNEL_NUM_IN*CHANNEL_NUM_OUT-1.

Reset
REQ-032 When reset==0 at a clock edge, the block SHALL enter IDLE and clear all counters, oc_idx and err to 0.
REQ-033 In reset, all outputs SHALL be 0, including w_rd_en, f_rd_en, valid_weight_out, valid_out, busy, done, weight_out and pxl_out.
REQ-034 Reset asserted mid-layer SHALL abort within that edge, with no further rd_en or valid pulses; in-flight memory data SHALL be discarded.

Verification (CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2, IMAGE_SIZE=3)
REQ-035 Full layer: start at cycle 0, adder returns 3 results per oc -> w_rd_addr 0..3 then 4..7, f_rd_addr 0..11 twice, done single pulse, oc_idx=1 at done.
REQ-036 Alignment: w_rd_data = address+100 -> weight_out sequence 100,101,102,103 on 4 consecutive valid_weight_out cycles; no overlap with valid_out.
REQ-037 Start while busy (at a STREAM cycle) -> no restart, addresses unaffected, single done at the end.
REQ-038 Early results: 3 result_valid_in pulses during STREAM -> FSM leaves WAIT_RES on the first WAIT_RES cycle; err stays 0.
REQ-039 Errors: result_valid_in in IDLE -> err=1; a 4th result in WAIT_RES for the same oc -> err=1; next start -> err=0.
REQ-040 Mid-operation reset: reset=0 for 1 cycle during LOAD_W of oc 1 -> all outputs 0 next cycle, busy=0, no done; a new start re-runs from oc 0.

Source files
------------

// File: rtl/conv_1x1_layer_ctrl_if.sv
// Bus between the 1x1 conv layer sequencer and its memories, conv datapath and host.
// The master modport is the sequencer; the slave modport is everything around it.
interface conv_1x1_layer_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int W_ADDR_WIDTH = 16,
  parameter int F_ADDR_WIDTH = 24,
  parameter int OC_W         = 9
);
  logic                    start;
  logic                    w_rd_en;
  logic [W_ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    f_rd_en;
  logic [F_ADDR_WIDTH-1:0] f_rd_addr;
  logic [DATA_WIDTH-1:0]   f_rd_data;
  logic [DATA_WIDTH-1:0]   weight_out;
  logic                    valid_weight_out;
  logic [DATA_WIDTH-1:0]   pxl_out;
  logic                    valid_out;
  logic                    result_valid_in;
  logic                    busy;
  logic                    done;
  logic [OC_W-1:0]         oc_idx;
  logic                    err;

  modport master (
    input  start, w_rd_data, f_rd_data, result_valid_in,
    output w_rd_en, w_rd_addr, f_rd_en, f_rd_addr, weight_out, valid_weight_out,
           pxl_out, valid_out, busy, done, oc_idx, err
  );

  modport slave (
    output start, w_rd_data, f_rd_data, result_valid_in,
    input  w_rd_en, w_rd_addr, f_rd_en, f_rd_addr, weight_out, valid_weight_out,
           pxl_out, valid_out, busy, done, oc_idx, err
  );
endinterface

// File: rtl/conv_1x1_layer_ctrl.sv
// 1x1 conv layer sequencer: per output channel, fetch CHANNEL_NUM_IN weights, stream the
// whole feature map, then wait for IMAGE_SIZE adder results before moving on.

// Read-return stage: memory data lands one cycle after rd_en and is registered out on the next.
module conv_1x1_rd_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);
  logic [1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      data     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en};
      if (vld_pipe[0]) data <= rd_data;
    end
  end

  assign valid = vld_pipe[1];
endmodule

module conv_1x1_layer_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 512,
  parameter int IMAGE_SIZE      = 306*306,
  parameter int W_ADDR_WIDTH    = 16,
  parameter int F_ADDR_WIDTH    = 24
) (
  input logic                   clk,
  input logic                   reset,
  conv_1x1_layer_ctrl_if.master bus
);
  localparam int OC_W   = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int WC_W   = $clog2(CHANNEL_NUM_IN + 1);
  localparam int RC_W   = $clog2(IMAGE_SIZE + 1);
  localparam int F_LAST = CHANNEL_NUM_IN * IMAGE_SIZE - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_FIN      = 3'd5;

  logic [2:0]              state;
  logic [WC_W-1:0]         w_cnt;
  logic [RC_W-1:0]         res_cnt;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [F_ADDR_WIDTH-1:0] f_addr;
  logic [OC_W-1:0]         oc;
  logic                    err_q;

  logic in_count, res_full, res_bad, start_ok, w_last, f_last, oc_last;

  assign in_count = (state == S_STREAM) || (state == S_WAIT_RES);
  assign res_full = (res_cnt == RC_W'(IMAGE_SIZE));
  // A result outside the counting window, or beyond IMAGE_SIZE, is an adder protocol error.
  assign res_bad  = bus.result_valid_in && (!in_count || res_full);
  assign start_ok = (state == S_IDLE) && bus.start;
  assign w_last   = (w_cnt == WC_W'(CHANNEL_NUM_IN - 1));
  assign f_last   = (f_addr == F_ADDR_WIDTH'(F_LAST));
  assign oc_last  = (oc == OC_W'(CHANNEL_NUM_OUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      w_cnt   <= '0;
      res_cnt <= '0;
      w_addr  <= '0;
      f_addr  <= '0;
      oc      <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_WAIT_RES && res_full)
        res_cnt <= '0;
      else if (in_count && bus.result_valid_in && !res_full)
        res_cnt <= res_cnt + RC_W'(1);

      if (start_ok)     err_q <= res_bad;
      else if (res_bad) err_q <= 1'b1;

      case (state)
        S_IDLE: if (bus.start) begin
          state   <= S_LOAD_W;
          oc      <= '0;
          w_addr  <= '0;
          w_cnt   <= '0;
          res_cnt <= '0;
        end
        S_LOAD_W: begin
          if (w_last) begin
            state  <= S_STREAM;
            f_addr <= '0;
          end else begin
            w_cnt  <= w_cnt + WC_W'(1);
            w_addr <= w_addr + W_ADDR_WIDTH'(1);
          end
        end
        S_STREAM: begin
          if (f_last) state  <= S_WAIT_RES;
          else        f_addr <= f_addr + F_ADDR_WIDTH'(1);
        end
        S_WAIT_RES: if (res_full) state <= S_NEXT;
        // Weight address only advances into a real next channel, so it parks at the last word.
        S_NEXT: begin
          if (oc_last) begin
            state <= S_FIN;
          end else begin
            state  <= S_LOAD_W;
            oc     <= oc + OC_W'(1);
            w_addr <= w_addr + W_ADDR_WIDTH'(1);
            w_cnt  <= '0;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [1:0]                 rd_en_v;
  logic [1:0][DATA_WIDTH-1:0] rd_data_v;
  logic [1:0][DATA_WIDTH-1:0] data_v;
  logic [1:0]                 valid_v;

  assign rd_en_v   = {bus.f_rd_en, bus.w_rd_en};
  assign rd_data_v = {bus.f_rd_data, bus.w_rd_data};

  // Lane 0 carries weights, lane 1 pixels; LOAD_W and STREAM never overlap so neither do the valids.
  conv_1x1_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe [1:0] (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en_v),
    .rd_data (rd_data_v),
    .data    (data_v),
    .valid   (valid_v)
  );

  assign bus.w_rd_en          = (state == S_LOAD_W);
  assign bus.w_rd_addr        = w_addr;
  assign bus.f_rd_en          = (state == S_STREAM);
  assign bus.f_rd_addr        = f_addr;
  assign bus.weight_out       = data_v[0];
  assign bus.valid_weight_out = valid_v[0];
  assign bus.pxl_out          = data_v[1];
  assign bus.valid_out        = valid_v[1];
  assign bus.busy             = (state != S_IDLE);
  assign bus.done             = (state == S_FIN);
  assign bus.oc_idx           = oc;
  assign bus.err              = err_q;
endmodule

// File: tb/tb_conv_1x1_layer_ctrl.sv
// Randomized bench for conv_1x1_layer_ctrl: memory models, an adder stub and a
// layer-level reference of address, data and timing sequences.
module tb_conv_1x1_layer_ctrl;
  localparam int CIN  = 4;
  localparam int COUT = 2;
  localparam int IMG  = 3;
  localparam int N    = CIN * IMG;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_1x1_layer_ctrl_if #(.DATA_WIDTH(DW), .W_ADDR_WIDTH(16), .F_ADDR_WIDTH(24), .OC_W(1)) bus ();

  conv_1x1_layer_ctrl #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .IMAGE_SIZE(IMG),
    .W_ADDR_WIDTH(16), .F_ADDR_WIDTH(24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memories: weight word = address + 100, feature words random per layer.
  logic [DW-1:0] f_mem [N];
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= DW'(bus.w_rd_addr) + DW'(100);
    if (bus.f_rd_en) bus.f_rd_data <= f_mem[bus.f_rd_addr];
  end

  // Observation queues filled away from the active edge.
  int cyc = 0;
  int obs_w_addr[$], obs_w_cyc[$], obs_f_addr[$], obs_f_cyc[$], obs_wt_cyc[$], obs_px_cyc[$];
  logic [DW-1:0] obs_wt[$], obs_px[$];
  int overlap_cnt, done_cnt, done_cyc;
  int done_oc;

  always @(negedge clk) begin
    cyc++;
    if (bus.w_rd_en) begin obs_w_addr.push_back(int'(bus.w_rd_addr)); obs_w_cyc.push_back(cyc); end
    if (bus.f_rd_en) begin obs_f_addr.push_back(int'(bus.f_rd_addr)); obs_f_cyc.push_back(cyc); end
    if (bus.valid_weight_out) begin obs_wt.push_back(bus.weight_out); obs_wt_cyc.push_back(cyc); end
    if (bus.valid_out) begin obs_px.push_back(bus.pxl_out); obs_px_cyc.push_back(cyc); end
    if (bus.valid_out && bus.valid_weight_out) overlap_cnt++;
    if (bus.done) begin done_cnt++; done_oc = int'(bus.oc_idx); done_cyc = cyc; end
  end

  task automatic clear_obs();
    obs_w_addr.delete(); obs_w_cyc.delete(); obs_f_addr.delete(); obs_f_cyc.delete();
    obs_wt.delete(); obs_wt_cyc.delete(); obs_px.delete(); obs_px_cyc.delete();
    overlap_cnt = 0; done_cnt = 0; done_cyc = 0; done_oc = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Adder stub: IMG results per channel once streaming begins. mode 1 keeps them inside
  // STREAM; mode 2 additionally fires a surplus result on channel 0's first WAIT_RES cycle.
  task automatic drive_results(input int n_oc, input int mode);
    int t;
    for (int oc = 0; oc < n_oc; oc++) begin
      t = 0;
      while (!bus.f_rd_en && t < 300) begin tick(); t++; end
      if (!bus.f_rd_en) begin chk("res_wait_to", 0, 1); return; end
      for (int k = 0; k < IMG; k++) begin
        repeat (mode != 0 ? $urandom_range(0, 2) : $urandom_range(0, 6)) tick();
        bus.result_valid_in = 1'b1;
        tick();
        bus.result_valid_in = 1'b0;
      end
      t = 0;
      while (bus.f_rd_en && t < 300) begin tick(); t++; end
      if (mode == 2 && oc == 0) begin
        bus.result_valid_in = 1'b1;
        tick();
        bus.result_valid_in = 1'b0;
      end
    end
  endtask

  task automatic restart_poke();
    int t = 0;
    while (!bus.f_rd_en && t < 300) begin tick(); t++; end
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_start();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Reference: channel oc reads weights oc*CIN+i and features 0..N-1, each echoed 2 cycles later.
  task automatic verify_layer(input bit exp_err, input bit early);
    int idx, last_w;
    chk("w_count", obs_w_addr.size(), CIN * COUT);
    chk("f_count", obs_f_addr.size(), N * COUT);
    chk("wt_count", obs_wt.size(), CIN * COUT);
    chk("px_count", obs_px.size(), N * COUT);
    if (obs_w_addr.size() == CIN * COUT && obs_wt.size() == CIN * COUT &&
        obs_f_addr.size() == N * COUT && obs_px.size() == N * COUT) begin
      for (int oc = 0; oc < COUT; oc++) begin
        for (int i = 0; i < CIN; i++) begin
          idx = oc * CIN + i;
          chk("w_addr", obs_w_addr[idx], oc * CIN + i);
          chk("wt_val", obs_wt[idx], oc * CIN + i + 100);
          chk("wt_lat", obs_wt_cyc[idx], obs_w_cyc[idx] + 2);
          if (i > 0) chk("wt_gap", obs_wt_cyc[idx], obs_wt_cyc[idx-1] + 1);
        end
        last_w = obs_w_cyc[oc * CIN + CIN - 1];
        for (int k = 0; k < N; k++) begin
          idx = oc * N + k;
          chk("f_addr", obs_f_addr[idx], k);
          chk("px_val", obs_px[idx], f_mem[k]);
          chk("px_lat", obs_px_cyc[idx], obs_f_cyc[idx] + 2);
          if (k == 0) chk("f_after_w", obs_f_cyc[idx] > last_w, 1);
        end
      end
      if (early) begin
        chk("oc_turn", obs_w_cyc[CIN], obs_f_cyc[N-1] + 3);
        chk("done_lat", done_cyc, obs_f_cyc[2*N-1] + 3);
      end
    end
    chk("overlap", overlap_cnt, 0);
    chk("done_cnt", done_cnt, 1);
    chk("done_oc", done_oc, COUT - 1);
    chk("oc_hold", bus.oc_idx, COUT - 1);
    chk("w_park", bus.w_rd_addr, CIN * COUT - 1);
    chk("busy_off", bus.busy, 0);
    chk("err_end", bus.err, exp_err);
  endtask

  task automatic run_layer(input int mode, input bit busy_start);
    int t;
    clear_obs();
    for (int i = 0; i < N; i++) f_mem[i] = $urandom;
    pulse_start();
    chk("busy_on", bus.busy, 1);
    chk("err_clr", bus.err, 0);
    fork
      drive_results(COUT, mode);
      begin
        if (busy_start) restart_poke();
      end
    join
    t = 0;
    while (bus.busy && t < 400) begin tick(); t++; end
    if (bus.busy) chk("idle_to", 0, 1);
    repeat (2) tick();
    verify_layer(mode == 2, mode != 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_w_en"}, bus.w_rd_en, 0);
    chk({tag, "_f_en"}, bus.f_rd_en, 0);
    chk({tag, "_vw"}, bus.valid_weight_out, 0);
    chk({tag, "_vp"}, bus.valid_out, 0);
    chk({tag, "_wt"}, bus.weight_out, 0);
    chk({tag, "_px"}, bus.pxl_out, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_oc"}, bus.oc_idx, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.result_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Stray result while idle.
    bus.result_valid_in = 1'b1;
    tick();
    bus.result_valid_in = 1'b0;
    chk("err_idle", bus.err, 1);
    chk("idle_busy", bus.busy, 0);

    run_layer(0, 1'b0);
    run_layer(1, 1'b0);
    run_layer(0, 1'b1);
    run_layer(2, 1'b0);
    run_layer(0, 1'b0);

    // Abort during LOAD_W of channel 1.
    clear_obs();
    for (int i = 0; i < N; i++) f_mem[i] = $urandom;
    pulse_start();
    drive_results(1, 1);
    t = 0;
    while (obs_w_addr.size() < CIN + 1 && t < 300) begin tick(); t++; end
    if (obs_w_addr.size() < CIN + 1) chk("abort_wait_to", 0, 1);
    chk("abort_oc", bus.oc_idx, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk); #1;
    check_quiet("abort");
    clear_obs();
    repeat (10) tick();
    chk("abort_w_pulses", obs_w_addr.size(), 0);
    chk("abort_f_pulses", obs_f_addr.size(), 0);
    chk("abort_valids", obs_wt.size() + obs_px.size(), 0);
    chk("abort_done", done_cnt, 0);

    run_layer(0, 1'b0);
    run_layer(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
